// File: rtl/psram_opi_resp.sv
// psram_opi_resp: OPI DDR PSRAM device-side responder. Oversamples SCK/CE/IO,
// decodes command/address/latency/data phases and serves a byte array plus a latency mode register.
`default_nettype none

module psram_opi_resp #(
    parameter int          DEPTH   = 1024,
    parameter logic [3:0]  LAT_RST = 4'd5,
    parameter logic [7:0]  CMD_RD  = 8'h00,
    parameter logic [7:0]  CMD_WR  = 8'h80,
    parameter logic [7:0]  CMD_MRR = 8'h40,
    parameter logic [7:0]  CMD_MRW = 8'hC0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_i,
    input  logic [7:0] psram_io_en_i,
    output logic [7:0] psram_io_o,
    output logic [7:0] psram_io_en_o,
    output logic       psram_dqs_o,
    output logic       psram_dqs_en_o,
    output logic       cmd_err_o,
    output logic [3:0] mode_lat_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_LAT    = 3'd3,
        ST_RDAT   = 3'd4,
        ST_WDAT   = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    state_t r_state, w_next;

    logic [1:0]    r_sck_s, r_ce_s;
    logic [7:0]    r_io_s1, r_io_s2;
    logic          r_sck_d;
    logic [7:0]    r_cmd;
    logic          r_cmd_vld;
    logic [1:0]    r_acnt;
    logic [3:0]    r_lcnt;
    logic [AW-1:0] r_addr;
    logic          r_mrw_done;
    logic [3:0]    r_lat;
    logic [7:0]    r_io_o, r_io_en;
    logic          r_dqs, r_dqs_en, r_err;
    logic [7:0]    r_mem [DEPTH];

    logic          w_rise, w_fall, w_edge, w_ce_hi, w_known, w_cmd_fail;
    logic [7:0]    w_io;
    logic [3:0]    w_lat_eff;
    logic [AW+7:0] w_addr_shift;
    logic [AW-1:0] w_addr_inc;
    logic          w_unused_io_en;

    assign w_unused_io_en = ^psram_io_en_i;
    assign w_rise       = r_sck_s[1] & ~r_sck_d;
    assign w_fall       = ~r_sck_s[1] & r_sck_d;
    assign w_edge       = w_rise | w_fall;
    assign w_ce_hi      = r_ce_s[1];
    assign w_io         = r_io_s2;
    assign w_lat_eff    = (r_lat == 4'd0) ? 4'd1 : r_lat;
    assign w_known      = (w_io == CMD_RD) || (w_io == CMD_WR) ||
                          (w_io == CMD_MRR) || (w_io == CMD_MRW);
    assign w_addr_shift = {r_addr, w_io};
    assign w_addr_inc   = r_addr + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_cmd_fail = 1'b0;
        case (r_state)
            ST_IDLE: w_next = ST_CMD;
            ST_CMD: begin
                if (w_fall && r_cmd_vld) begin
                    if (w_known && (w_io == r_cmd)) begin
                        w_next = ST_ADDR;
                    end else begin
                        w_next     = ST_IGNORE;
                        w_cmd_fail = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (w_edge && (r_acnt == 2'd3))
                    w_next = (r_cmd == CMD_MRW) ? ST_WDAT : ST_LAT;
            end
            ST_LAT: begin
                // The fall edge of the last counted cycle still belongs to latency.
                if (w_fall && (r_lcnt == w_lat_eff))
                    w_next = ((r_cmd == CMD_RD) || (r_cmd == CMD_MRR)) ? ST_RDAT : ST_WDAT;
            end
            default: w_next = r_state;
        endcase
        if (w_ce_hi) begin
            w_next     = ST_IDLE;
            w_cmd_fail = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sck_s    <= 2'b00;
            r_ce_s     <= 2'b11;
            r_io_s1    <= 8'h00;
            r_io_s2    <= 8'h00;
            r_sck_d    <= 1'b0;
            r_cmd      <= 8'h00;
            r_cmd_vld  <= 1'b0;
            r_acnt     <= 2'd0;
            r_lcnt     <= 4'd0;
            r_addr     <= '0;
            r_mrw_done <= 1'b0;
            r_lat      <= LAT_RST;
            r_io_o     <= 8'h00;
            r_io_en    <= 8'h00;
            r_dqs      <= 1'b0;
            r_dqs_en   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_sck_s <= {r_sck_s[0], psram_sck_i};
            r_ce_s  <= {r_ce_s[0], psram_ce_i};
            r_io_s1 <= psram_io_i;
            r_io_s2 <= r_io_s1;
            r_sck_d <= r_sck_s[1];
            r_err   <= w_cmd_fail;
            if (w_ce_hi) begin
                r_io_en    <= 8'h00;
                r_dqs_en   <= 1'b0;
                r_dqs      <= 1'b0;
                r_cmd_vld  <= 1'b0;
                r_acnt     <= 2'd0;
                r_lcnt     <= 4'd0;
                r_mrw_done <= 1'b0;
            end else begin
                case (r_state)
                    ST_CMD: begin
                        if (w_rise) begin
                            r_cmd     <= w_io;
                            r_cmd_vld <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        if (w_edge) begin
                            r_acnt <= r_acnt + 2'd1;
                            // Only the low address bits are kept; bursts always start even.
                            if (r_acnt == 2'd3) r_addr <= {w_addr_shift[AW-1:1], 1'b0};
                            else                r_addr <= w_addr_shift[AW-1:0];
                        end
                    end
                    ST_LAT: begin
                        if (w_rise) r_lcnt <= r_lcnt + 4'd1;
                    end
                    ST_RDAT: begin
                        if (w_edge) begin
                            r_io_en  <= 8'hFF;
                            r_dqs_en <= 1'b1;
                            r_dqs    <= ~r_dqs;
                            if (r_cmd == CMD_MRR) begin
                                r_io_o <= {4'b0000, r_lat};
                            end else begin
                                r_io_o <= r_mem[r_addr];
                                r_addr <= w_addr_inc;
                            end
                        end
                    end
                    ST_WDAT: begin
                        if (w_edge) begin
                            if (r_cmd == CMD_MRW) begin
                                if (!r_mrw_done) begin
                                    r_lat      <= w_io[3:0];
                                    r_mrw_done <= 1'b1;
                                end
                            end else begin
                                r_addr <= w_addr_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if ((r_state == ST_WDAT) && w_edge && !w_ce_hi && (r_cmd != CMD_MRW))
            r_mem[r_addr] <= w_io;
    end

    assign psram_io_o     = r_io_o;
    assign psram_io_en_o  = r_io_en;
    assign psram_dqs_o    = r_dqs;
    assign psram_dqs_en_o = r_dqs_en;
    assign cmd_err_o      = r_err;
    assign mode_lat_o     = r_lat;

endmodule

`default_nettype wire

// File: tb/tb_psram_opi_resp.sv
// tb_psram_opi_resp: drives OPI transactions as a controller would; read bytes are
// checked by a scoreboard monitor triggered on every DQS toggle.
`default_nettype none

module tb_psram_opi_resp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       ce = 1'b1;
    logic [7:0] io = 8'h00;
    logic [7:0] io_en_c = 8'h00;
    logic [7:0] io_o, io_en_o;
    logic       dqs_o, dqs_en_o, cmd_err_o;
    logic [3:0] mode_lat_o;

    int         total = 0;
    int         bad = 0;
    int         errs = 0;
    logic [8:0] q[$];
    logic [8:0] exp_m;
    logic       prev_dqs = 1'b0;

    psram_opi_resp dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .psram_sck_i    (sck),
        .psram_ce_i     (ce),
        .psram_io_i     (io),
        .psram_io_en_i  (io_en_c),
        .psram_io_o     (io_o),
        .psram_io_en_o  (io_en_o),
        .psram_dqs_o    (dqs_o),
        .psram_dqs_en_o (dqs_en_o),
        .cmd_err_o      (cmd_err_o),
        .mode_lat_o     (mode_lat_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Monitor: every DQS toggle while driven is one read byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_err_o) errs++;
            if (dqs_en_o && (dqs_o !== prev_dqs)) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got %h want none", io_o);
                end else begin
                    exp_m = q.pop_front();
                    chk("rd_data", {16'h0, io_en_o, dqs_o, 7'h0, io_o},
                        {16'h0, 8'hFF, exp_m[8], 7'h0, exp_m[7:0]});
                end
            end
        end
        prev_dqs = dqs_o;
    end

    task automatic half(input logic [7:0] b, input logic lvl);
        @(negedge clk) io = b;
        repeat (2) @(negedge clk);
        sck = lvl;
        repeat (2) @(negedge clk);
    endtask

    task automatic cyc(input logic [7:0] b0, input logic [7:0] b1);
        half(b0, 1'b1);
        half(b1, 1'b0);
    endtask

    task automatic start();
        @(negedge clk) ce = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic stop();
        repeat (4) @(negedge clk);
        ce = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic cmd_addr(input logic [7:0] c0, input logic [7:0] c1, input logic [31:0] a);
        cyc(c0, c1);
        cyc(a[31:24], a[23:16]);
        cyc(a[15:8], a[7:0]);
    endtask

    task automatic wr(input logic [7:0] c, input logic [31:0] a, input int l,
                      input logic [31:0] d, input int n);
        start();
        cmd_addr(c, c, a);
        repeat (l) cyc(8'h00, 8'h00);
        for (int i = 0; i < n; i += 2) cyc(d[31-8*i -: 8], d[23-8*i -: 8]);
        stop();
    endtask

    // Leaves CE low so the caller decides between a normal end and an abort.
    task automatic rd(input logic [7:0] c, input logic [31:0] a, input int l,
                      input logic [31:0] d, input int n);
        logic b;
        start();
        cmd_addr(c, c, a);
        for (int i = 0; i < n; i++) begin
            b = (i % 2 == 0);
            q.push_back({b, d[31-8*i -: 8]});
        end
        repeat (l) cyc(8'h00, 8'h00);
        for (int i = 0; i < n; i += 2) cyc(8'h00, 8'h00);
        repeat (4) @(negedge clk);
        chk("rd_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic bad_cmd(input logic [7:0] c0, input logic [7:0] c1);
        int e0;
        e0 = errs;
        start();
        cmd_addr(c0, c1, 32'h0000_0010);
        repeat (3) cyc(8'h00, 8'h00);
        chk("err_no_drive", {io_en_o, 7'h0, dqs_en_o}, 16'h0);
        stop();
        chk("err_pulses", errs - e0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_io", io_o, 8'h00);
        chk("rst_io_en", io_en_o, 8'h00);
        chk("rst_dqs", dqs_o, 1'b0);
        chk("rst_dqs_en", dqs_en_o, 1'b0);
        chk("rst_err", cmd_err_o, 1'b0);
        chk("rst_lat", mode_lat_o, 4'd5);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_no_drive", {io_en_o, 7'h0, dqs_en_o}, 16'h0);

        wr(8'h80, 32'h0000_0010, 5, 32'hA1B2C3D4, 4);
        rd(8'h00, 32'h0000_0010, 5, 32'hA1B2C3D4, 4); stop();

        wr(8'h80, 32'h0000_03FE, 5, 32'h11223344, 4);
        rd(8'h00, 32'h0000_03FE, 5, 32'h11223344, 4); stop();
        rd(8'h00, 32'h0000_0011, 5, 32'hA1B20000, 2); stop();
        rd(8'h00, 32'h0000_0000, 5, 32'h33440000, 2); stop();

        wr(8'hC0, 32'h0000_0000, 0, 32'h03030000, 2);
        chk("mrw_lat", mode_lat_o, 4'd3);
        rd(8'h40, 32'h0000_0000, 3, 32'h03030000, 2); stop();
        rd(8'h00, 32'h0000_0010, 3, 32'hA1B2C3D4, 4); stop();

        bad_cmd(8'h80, 8'h00);
        bad_cmd(8'h22, 8'h22);

        rd(8'h00, 32'h0000_0010, 3, 32'hA1B20000, 2);
        ce = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_drop", {io_en_o, 7'h0, dqs_en_o}, 16'h0);
        chk("abort_dqs", dqs_o, 1'b0);
        repeat (6) @(negedge clk);

        wr(8'h80, 32'h0000_0020, 3, 32'h5A6B0000, 2);
        rd(8'h00, 32'h0000_0020, 3, 32'h5A6B0000, 2); stop();
        chk("final_lat", mode_lat_o, 4'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psram_opi_resp.md
Name: psram_opi_resp

Overview:
- Synthesizable OPI DDR PSRAM device-side responder: the memory end of the psram interface, driven by the team's PSRAM controller.
- Oversamples the controller's SCK/CE/IO on the system clock and decodes command, address, latency and data phases.
- Serves reads and writes from an internal byte array and holds one mode register (read/write latency).
- Used in FPGA emulation and as a synthesizable bench partner for the controller.

Parameters:
- DEPTH, 1024: bytes of backing storage; power of two; addresses wrap modulo DEPTH.
- LAT_RST, 5: reset value of the latency field (SCK cycles).
- CMD_RD, 8'h00: sync read command.
- CMD_WR, 8'h80: sync write command.
- CMD_MRR, 8'h40: mode-register read command.
- CMD_MRW, 8'hC0: mode-register write command.

Ports:
- clk_i  in  1  system clock, at least 4x SCK frequency.
- rst_n_i  in  1  asynchronous active-low reset.
- psram_sck_i  in  1  SCK from the controller.
- psram_ce_i  in  1  chip enable from the controller, active low.
- psram_io_i  in  8  IO driven by the controller.
- psram_io_en_i  in  8  controller IO output enable; informational, not used for decode.
- psram_io_o  out  8  read data to the controller.
- psram_io_en_o  out  8  responder IO drive enable (all 8 bits move together).
- psram_dqs_o  out  1  read strobe.
- psram_dqs_en_o  out  1  DQS drive enable.
- cmd_err_o  out  1  one-clk pulse on an illegal or mismatched command.
- mode_lat_o  out  4  current latency field.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: psram_io_o=0, psram_io_en_o=0, psram_dqs_o=0, psram_dqs_en_o=0, cmd_err_o=0, mode_lat_o=LAT_RST, state=IDLE. Memory contents are not reset.
- Input synchronisation: SCK, CE and IO pass through identical 2-flop synchronisers. Rise and fall edges are detected on the synced SCK, and synced IO is sampled on the detection cycle.
- CE abort: synced CE high at any time (mid-operation included) -> state IDLE next clk. io_en_o, dqs_en_o and dqs_o clear in the same update. Any byte already written stays written.
- IDLE: CE low -> CMD.
- CMD: byte captured on rise and fall of SCK cycle 1.
  - Bytes equal and a known command -> ADDR.
  - Otherwise -> IGNORE with a cmd_err_o pulse.
- ADDR: 4 bytes, one per edge over 2 SCK cycles, MSB first. Address = low log2(DEPTH) bits with bit0 forced to 0 (bursts start even).
- After ADDR:
  - MRW -> WDAT immediately (no latency).
  - All other commands -> LAT.
- LAT:
  - Counts L rising edges, where L = mode_lat_o and 0 is treated as 1; the Lth cycle's fall edge is also latency.
  - RD/MRR -> RDAT.
  - WR -> WDAT.
- RDAT:
  - Entered at the next rise edge; io_en_o=8'hFF and dqs_en_o=1 one clk after that edge.
  - Each detected edge, one clk later: io_o <= mem[addr]; dqs_o toggles, starting 0->1; addr increments mod DEPTH.
  - No burst-length limit.
  - MRR returns {4'b0, mode_lat} on every edge with no increment.
- WDAT:
  - Each edge: mem[addr] <= io byte; addr increments mod DEPTH.
  - MRW: the first edge loads mode_lat <= byte[3:0]; later edges are ignored.
  - Bursts shorter than 2 bytes are legal for the responder.
- IGNORE: outputs undriven until CE high.
- Edge collision: a rise and fall cannot occur in one clk because of the 4x requirement; no handling is required.

Test Plan:
- Reset: hold rst_n_i low -> all outputs 0, mode_lat_o=5; release with CE high -> state IDLE, no drive.
- Write: WR (80/80), addr 0x00000010, L=5, bytes A1 B2 C3 D4 -> then RD same addr returns A1 B2 C3 D4, dqs_o toggling 1,0,1,0, first byte on the first rise after 5 latency cycles.
- Wrap and odd address: write at addr 0x3FE with DEPTH=1024, 4 bytes 11 22 33 44 -> read at 0x3FE returns 11 22 33 44 (0x3FE, 0x3FF, 0x000, 0x001); a read issued at 0x011 starts at 0x010.
- Mode register: MRW (C0/C0) data 0x03 -> mode_lat_o=3; MRR -> 0x03 after 3 cycles; the next RD's first data lands on rise edge 4.
- Command errors: cmd bytes 80/00 -> cmd_err_o pulses once, no drive until CE high; unknown code 0x22 -> same behaviour.
- CE abort: raise CE after 2 of 4 read bytes -> io_en_o/dqs_en_o drop within 3 clk; a following WR works normally.
